nn_alu_pipe: RTL
================

Name: nn_alu_pipe

Overview:
- Parametrised, pipelined successor to the NN execution-unit ALU.
- Accepts one (op, SrcA, SrcB) per cycle over a valid/ready handshake and returns results two cycles later.
- Adds signed arithmetic, an internal multiply-accumulate register for neuron dot products, optional saturation, ReLU, and overflow flagging.
- Sits between the register-file read stage and the writeback stage of the NN datapath.

Parameters:
- NBITS, 32, operand/result width; two's-complement signed.
- SATURATE, 1, 1 = ADD/MUL/MAC clamp to signed range; 0 = wrap (truncate).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  op/operands present.
- in_ready  out  1  block can accept this cycle.
- ALUControl  in  3  operation code.
- SrcA  in  NBITS  operand A (signed).
- SrcB  in  NBITS  operand B (signed).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- ALUResult  out  NBITS  result.
- out_ovf  out  1  result was saturated or wrapped.
- acc_value  out  NBITS  current accumulator contents (debug).

Behaviour:
- Op codes:
  - 000 ADD: A+B.
  - 001 MUL: A*B, with the 2*NBITS product reduced to NBITS.
  - 010 SGE: signed A>=B gives 1, else 0.
  - 011 MAC: acc <= acc + A*B; result = new acc.
  - 100 RELU: A<0 gives 0, else A.
  - 101 ACC_CLR: result = old acc; acc <= 0.
  - 110: reserved; result 0.
  - 111 PASS: A.
- Width rules:
  - ADD is computed at NBITS+1 bits.
  - MUL and MAC products are computed at 2*NBITS bits.
  - MAC sum is computed at 2*NBITS+1 bits, then reduced to NBITS.
- Reduction:
  - SATURATE=1: clamp to [-2^(NBITS-1), 2^(NBITS-1)-1].
  - SATURATE=0: keep the low NBITS bits.
  - In either mode, out_ovf=1 iff the exact value is outside the NBITS signed range.
  - out_ovf=0 for SGE, RELU, ACC_CLR, reserved and PASS.
- Pipeline stages:
  - Stage S1 registers op, A and B.
  - Stage S2 registers result, ovf and valid.
  - Combinational compute sits between S1 and S2.
- Handshake:
  - advance = !s2_valid | out_ready.
  - in_ready = !s1_valid | advance.
  - Input is accepted when in_valid & in_ready.
  - S1 moves to S2 when s1_valid & advance.
  - out_valid = s2_valid.
  - ALUResult/out_ovf hold stable while out_valid & !out_ready.
- Latency: an op accepted in cycle t appears on out_valid in cycle t+2 if out_ready stayed high. Sustained throughput is 1 op/cycle.
- Backpressure: while out_ready=0 with both stages full, in_ready=0 and no state changes.
- Accumulator:
  - Updated only in the cycle an op moves from S1 to S2, so a stalled MAC never double-accumulates.
  - Back-to-back MACs chain correctly: the second uses the acc written by the first.
  - MAC reduces the stored acc by the same SATURATE rule.
- ALUControl/SrcA/SrcB are ignored when in_valid=0.
- Reset (synchronous, any time including mid-stall):
  - s1_valid=0, s2_valid=0, acc=0, ALUResult=0, out_ovf=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - In-flight ops are discarded.
- Simultaneous accept and output in the same cycle is legal and required for full throughput.

Decomposition:
- Package nn_alu_pkg holds:
  - op-code constants (ALU_ADD, ALU_MUL, ALU_SGE, ALU_MAC, ALU_RELU, ALU_ACC_CLR, ALU_PASS);
  - a 3-bit op typedef;
  - a function computing the signed NBITS min and max.
- One sub-module, nn_sat_reduce: a combinational reducer from a wide signed value to NBITS plus an ovf flag, parametrised by input width and SATURATE. It is instantiated for ADD, MUL and MAC.

Test Plan:
- ADD/SGE/PASS/RELU basics, NBITS=32, out_ready=1:
  - ADD 5,-7 gives -2 at cycle t+2.
  - SGE -2,0 gives 0.
  - PASS 0x1234 gives 0x1234.
  - RELU -9 gives 0; RELU 9 gives 9.
  - out_ovf=0 throughout.
- Saturation, SATURATE=1:
  - ADD 0x7FFFFFFF,1 gives 0x7FFFFFFF with ovf=1.
  - MUL 0x10000,0x10000 gives 0x7FFFFFFF with ovf=1.
  - MUL -0x10000,0x10000 gives 0x80000000 with ovf=1.
- Wrap, SATURATE=0: ADD 0x7FFFFFFF,1 gives 0x80000000 with ovf=1.
- MAC chain, back-to-back every cycle:
  - Sequence ACC_CLR, MAC(2,3), MAC(4,5), MAC(-1,6).
  - Results: old acc, 6, 26, 20; acc_value ends at 20.
- Backpressure:
  - Issue MAC(1,1) x3 with out_ready held 0 for 4 cycles.
  - in_ready drops to 0 after two accepts and the held result stays stable.
  - After release the results are 1, 2, 3, with no double-accumulation.
- Reset mid-operation:
  - Assert reset with both stages full and acc=20.
  - Next cycle: out_valid=0, ALUResult=0, acc_value=0, in_ready=1.
  - A following MAC(2,2) returns 4.

Source files
------------

// File: rtl/nn_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_alu_pkg                                                           |
// | Op codes, op type and signed range helper for the NN pipelined ALU.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nn_alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD     = 3'b000;
  localparam alu_op_t ALU_MUL     = 3'b001;
  localparam alu_op_t ALU_SGE     = 3'b010;
  localparam alu_op_t ALU_MAC     = 3'b011;
  localparam alu_op_t ALU_RELU    = 3'b100;
  localparam alu_op_t ALU_ACC_CLR = 3'b101;
  localparam alu_op_t ALU_PASS    = 3'b111;

  // Wide enough to hold the limits of any practical operand width.
  localparam int LIMIT_W = 129;

  function automatic logic signed [LIMIT_W-1:0] sat_limit(input int nbits, input logic is_max);
    logic signed [LIMIT_W-1:0] lim;
    lim = LIMIT_W'(1) << (nbits - 1);
    return is_max ? (lim - LIMIT_W'(1)) : -lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_sat_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_sat_reduce                                                        |
// | Reduces a wide signed value to NBITS (clamp or wrap) with ovf flag.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nn_sat_reduce
  import nn_alu_pkg::*;
#(
  parameter int IN_W     = 33,
  parameter int NBITS    = 32,
  parameter int SATURATE = 1
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic        [NBITS-1:0] o_val,
  output logic                    o_ovf
);

  localparam logic signed [IN_W-1:0] C_MAX = IN_W'(sat_limit(NBITS, 1'b1));
  localparam logic signed [IN_W-1:0] C_MIN = IN_W'(sat_limit(NBITS, 1'b0));

  logic w_hi;
  logic w_lo;

  assign w_hi = (i_val > C_MAX);
  assign w_lo = (i_val < C_MIN);

  always_comb begin
    o_ovf = w_hi | w_lo;
    o_val = i_val[NBITS-1:0];
    if (SATURATE != 0) begin
      if (w_hi) begin
        o_val = C_MAX[NBITS-1:0];
      end else if (w_lo) begin
        o_val = C_MIN[NBITS-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_alu_pipe                                                          |
// | Two-stage valid/ready NN ALU with MAC accumulator and saturation.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nn_alu_pipe
  import nn_alu_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [NBITS-1:0] SrcA,
  input  logic [NBITS-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] ALUResult,
  output logic             out_ovf,
  output logic [NBITS-1:0] acc_value
);

  localparam int PW = 2 * NBITS;

  logic             r_s1_valid;
  alu_op_t          r_s1_op;
  logic [NBITS-1:0] r_s1_a;
  logic [NBITS-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [NBITS-1:0] r_s2_result;
  logic             r_s2_ovf;
  logic [NBITS-1:0] r_acc;

  logic w_advance;
  logic w_accept;
  logic w_move;

  logic signed [NBITS:0]  w_add_sum;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW:0]     w_mac_sum;
  logic [NBITS-1:0]       w_add_red;
  logic [NBITS-1:0]       w_mul_red;
  logic [NBITS-1:0]       w_mac_red;
  logic                   w_add_ovf;
  logic                   w_mul_ovf;
  logic                   w_mac_ovf;
  logic [NBITS-1:0]       w_result;
  logic                   w_ovf;

  assign w_advance = !r_s2_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_advance;
  assign w_accept  = in_valid & in_ready;
  assign w_move    = r_s1_valid & w_advance;

  assign w_add_sum = {r_s1_a[NBITS-1], r_s1_a} + {r_s1_b[NBITS-1], r_s1_b};
  assign w_prod    = $signed({{NBITS{r_s1_a[NBITS-1]}}, r_s1_a})
                   * $signed({{NBITS{r_s1_b[NBITS-1]}}, r_s1_b});
  assign w_mac_sum = {{(NBITS+1){r_acc[NBITS-1]}}, r_acc} + {w_prod[PW-1], w_prod};

  nn_sat_reduce #(.IN_W(NBITS+1), .NBITS(NBITS), .SATURATE(SATURATE)) u_add_red (
    .i_val(w_add_sum), .o_val(w_add_red), .o_ovf(w_add_ovf)
  );

  nn_sat_reduce #(.IN_W(PW), .NBITS(NBITS), .SATURATE(SATURATE)) u_mul_red (
    .i_val(w_prod), .o_val(w_mul_red), .o_ovf(w_mul_ovf)
  );

  nn_sat_reduce #(.IN_W(PW+1), .NBITS(NBITS), .SATURATE(SATURATE)) u_mac_red (
    .i_val(w_mac_sum), .o_val(w_mac_red), .o_ovf(w_mac_ovf)
  );

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (r_s1_op)
      ALU_ADD: begin
        w_result = w_add_red;
        w_ovf    = w_add_ovf;
      end
      ALU_MUL: begin
        w_result = w_mul_red;
        w_ovf    = w_mul_ovf;
      end
      ALU_SGE:     w_result = {{(NBITS-1){1'b0}}, ($signed(r_s1_a) >= $signed(r_s1_b))};
      ALU_MAC: begin
        w_result = w_mac_red;
        w_ovf    = w_mac_ovf;
      end
      ALU_RELU:    w_result = r_s1_a[NBITS-1] ? '0 : r_s1_a;
      ALU_ACC_CLR: w_result = r_acc;
      ALU_PASS:    w_result = r_s1_a;
      default:     w_result = '0;
    endcase
  end

  // The accumulator only commits when S1 hands over, so a stalled MAC is applied once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= ALU_ADD;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_ovf    <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= ALUControl;
        r_s1_a     <= SrcA;
        r_s1_b     <= SrcB;
      end else if (w_move) begin
        r_s1_valid <= 1'b0;
      end
      if (w_advance) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_move) begin
        r_s2_result <= w_result;
        r_s2_ovf    <= w_ovf;
        if (r_s1_op == ALU_MAC) begin
          r_acc <= w_mac_red;
        end else if (r_s1_op == ALU_ACC_CLR) begin
          r_acc <= '0;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign ALUResult = r_s2_result;
  assign out_ovf   = r_s2_ovf;
  assign acc_value = r_acc;

endmodule
`default_nettype wire
